// File: rtl/filter_frame_sequencer_pkg.sv
// Shared types and defaults for the video-effects stream blocks. The filter
// frame sequencer and its mode debouncer import this package.
package vfx_stream_pkg;

    localparam int IMG_W_DEFAULT         = 320;
    localparam int IMG_H_DEFAULT         = 240;
    localparam int DATA_W_DEFAULT        = 12;
    localparam int STABLE_FRAMES_DEFAULT = 2;

    // Counter widths are fixed so downstream filters see the same
    // row/col bus whatever image size is configured.
    localparam int COL_W  = 10;
    localparam int ROW_W  = 9;
    localparam int MODE_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DROP   = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        PASS      = 2'd0,
        BLUR      = 2'd1,
        EDGE      = 2'd2,
        FACE_BLUR = 2'd3
    } filter_mode_t;

    // True when (row, col) is the final pixel position of a frame.
    function automatic logic pos_is_last(
        input logic [COL_W-1:0] col,
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col_last,
        input logic [ROW_W-1:0] row_last
    );
        return (col == col_last) && (row == row_last);
    endfunction

endpackage

// File: rtl/filter_frame_sequencer_if.sv
// Stream bus between the upstream pixel source, the frame sequencer and the
// filter bank. The slave modport is the sequencer's view; the master modport
// is the view of whoever drives the source side and sinks the filtered side.
interface filter_frame_sequencer_if #(
    parameter int DATA_W = 12
);
    // Upstream side
    logic              valid_in;
    logic              ready_out;
    logic              sop_in;
    logic              eop_in;
    logic [DATA_W-1:0] data_in;
    logic [1:0]        freq_flag;

    // Downstream (filter) side
    logic              valid_out;
    logic              ready_in;
    logic              sop_out;
    logic              eop_out;
    logic [DATA_W-1:0] data_out;
    logic [9:0]        col_out;
    logic [8:0]        row_out;
    logic [1:0]        mode_out;
    logic              len_error;
    logic [15:0]       frame_count;

    modport slave (
        input  valid_in, sop_in, eop_in, data_in, freq_flag, ready_in,
        output ready_out, valid_out, sop_out, eop_out, data_out,
               col_out, row_out, mode_out, len_error, frame_count
    );

    modport master (
        output valid_in, sop_in, eop_in, data_in, freq_flag, ready_in,
        input  ready_out, valid_out, sop_out, eop_out, data_out,
               col_out, row_out, mode_out, len_error, frame_count
    );

endinterface

// File: rtl/filter_frame_sequencer_mode_debouncer.sv
// Filter-mode debouncer: the audio band flag must be seen on STABLE_FRAMES
// consecutive start-of-frame beats before the filter mode follows it. It is
// only strobed by accepted SOP beats, so the mode can never move mid-frame.
module mode_debouncer
    import vfx_stream_pkg::*;
#(
    parameter int STABLE_FRAMES = STABLE_FRAMES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_sop_strobe,
    input  logic [1:0]   i_freq_flag,
    output filter_mode_t o_mode
);

    localparam int               CNT_W   = $clog2(STABLE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_FRAMES);

    logic [1:0]       r_candidate;
    logic [CNT_W-1:0] r_stable_cnt;
    filter_mode_t     r_mode;

    logic [1:0]       w_candidate_nx;
    logic [CNT_W-1:0] w_stable_cnt_nx;

    // Next candidate/count: saturate on a repeat, restart on a new flag value.
    always_comb begin
        w_candidate_nx  = r_candidate;
        w_stable_cnt_nx = r_stable_cnt;
        if (i_freq_flag == r_candidate) begin
            if (r_stable_cnt >= CNT_MAX) begin
                w_stable_cnt_nx = CNT_MAX;
            end else begin
                w_stable_cnt_nx = r_stable_cnt + CNT_W'(1);
            end
        end else begin
            w_candidate_nx  = i_freq_flag;
            w_stable_cnt_nx = CNT_W'(1);
        end
    end

    // Debounce state; mode updates on the same edge that loads the SOP beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_candidate  <= 2'd0;
            r_stable_cnt <= '0;
            r_mode       <= PASS;
        end else if (i_sop_strobe) begin
            r_candidate  <= w_candidate_nx;
            r_stable_cnt <= w_stable_cnt_nx;
            if (w_stable_cnt_nx == CNT_MAX) begin
                r_mode <= filter_mode_t'(w_candidate_nx);
            end else begin
                r_mode <= r_mode;
            end
        end else begin
            r_candidate  <= r_candidate;
            r_stable_cnt <= r_stable_cnt;
            r_mode       <= r_mode;
        end
    end

    assign o_mode = r_mode;

endmodule

// File: rtl/filter_frame_sequencer.sv
// Frame-level controller in front of the pixel filter bank. One registered
// stream stage that enforces fixed IMG_W x IMG_H framing, publishes the
// row/col of every emitted pixel, drops beats that arrive outside a frame,
// flags framing violations and hands the debounced filter mode downstream.
module filter_frame_sequencer
    import vfx_stream_pkg::*;
#(
    parameter int IMG_W         = IMG_W_DEFAULT,
    parameter int IMG_H         = IMG_H_DEFAULT,
    parameter int DATA_W        = DATA_W_DEFAULT,
    parameter int STABLE_FRAMES = STABLE_FRAMES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    filter_frame_sequencer_if.slave bus
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    // Registered state and outputs
    seq_state_t        r_state;
    logic              r_valid_out;
    logic              r_sop_out;
    logic              r_eop_out;
    logic [DATA_W-1:0] r_data_out;
    logic [COL_W-1:0]  r_col_out;
    logic [ROW_W-1:0]  r_row_out;
    logic              r_len_error;
    logic [15:0]       r_frame_count;

    // Handshake and beat decode
    logic              w_ready_out;
    logic              w_accept;
    logic              w_sop_strobe;
    logic [COL_W-1:0]  w_next_col;
    logic [ROW_W-1:0]  w_next_row;
    logic              w_emit;
    logic              w_emit_sop;
    logic              w_emit_eop;
    logic [COL_W-1:0]  w_emit_col;
    logic [ROW_W-1:0]  w_emit_row;
    logic              w_err;
    logic              w_frame_done;
    seq_state_t        w_state_nx;
    filter_mode_t      w_mode;

    // The stage can take a beat when empty or when its beat leaves this cycle.
    assign w_ready_out  = ~r_valid_out | bus.ready_in;
    assign w_accept     = bus.valid_in & w_ready_out;
    assign w_sop_strobe = w_accept & bus.sop_in;

    // In ACTIVE the output register always holds the previous pixel of the
    // frame, so the next position is derived from it; the last position
    // always leaves ACTIVE, so the row increment cannot overflow.
    assign w_next_col = (r_col_out == COL_LAST) ? {COL_W{1'b0}} : (r_col_out + 10'd1);
    assign w_next_row = (r_col_out == COL_LAST) ? (r_row_out + 9'd1) : r_row_out;

    // Classify the accepted beat: emit or drop, flags, position, next state.
    always_comb begin
        w_emit       = 1'b0;
        w_emit_sop   = 1'b0;
        w_emit_eop   = 1'b0;
        w_emit_col   = {COL_W{1'b0}};
        w_emit_row   = {ROW_W{1'b0}};
        w_err        = 1'b0;
        w_frame_done = 1'b0;
        w_state_nx   = r_state;
        if (w_accept) begin
            case (r_state)
                IDLE, DROP: begin
                    if (bus.sop_in) begin
                        w_emit     = 1'b1;
                        w_emit_sop = 1'b1;
                        if (bus.eop_in) begin
                            w_emit_eop = 1'b1;
                            w_err      = 1'b1;
                            w_state_nx = IDLE;
                        end else begin
                            w_state_nx = ACTIVE;
                        end
                    end else begin
                        w_state_nx = r_state;
                    end
                end
                ACTIVE: begin
                    w_emit = 1'b1;
                    if (bus.sop_in) begin
                        // Restart: the interrupted frame never gets an EOP.
                        w_emit_sop = 1'b1;
                        w_err      = 1'b1;
                        if (bus.eop_in) begin
                            w_emit_eop = 1'b1;
                            w_state_nx = IDLE;
                        end else begin
                            w_state_nx = ACTIVE;
                        end
                    end else begin
                        w_emit_col = w_next_col;
                        w_emit_row = w_next_row;
                        if (pos_is_last(w_next_col, w_next_row, COL_LAST, ROW_LAST)) begin
                            w_emit_eop   = 1'b1;
                            w_frame_done = 1'b1;
                            if (bus.eop_in) begin
                                w_state_nx = IDLE;
                            end else begin
                                w_err      = 1'b1;
                                w_state_nx = DROP;
                            end
                        end else if (bus.eop_in) begin
                            w_emit_eop = 1'b1;
                            w_err      = 1'b1;
                            w_state_nx = IDLE;
                        end else begin
                            w_state_nx = ACTIVE;
                        end
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                end
            endcase
        end else begin
            w_state_nx = r_state;
        end
    end

    // Framing FSM and output register: load on accept, drain on ready, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_valid_out   <= 1'b0;
            r_sop_out     <= 1'b0;
            r_eop_out     <= 1'b0;
            r_data_out    <= {DATA_W{1'b0}};
            r_col_out     <= {COL_W{1'b0}};
            r_row_out     <= {ROW_W{1'b0}};
            r_len_error   <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            r_len_error <= w_accept & w_err;
            if (w_accept) begin
                r_state     <= w_state_nx;
                r_valid_out <= w_emit;
                if (w_emit) begin
                    r_sop_out  <= w_emit_sop;
                    r_eop_out  <= w_emit_eop;
                    r_data_out <= bus.data_in;
                    r_col_out  <= w_emit_col;
                    r_row_out  <= w_emit_row;
                end else begin
                    r_sop_out <= 1'b0;
                    r_eop_out <= 1'b0;
                end
                if (w_frame_done) begin
                    r_frame_count <= r_frame_count + 16'd1;
                end else begin
                    r_frame_count <= r_frame_count;
                end
            end else if (bus.ready_in) begin
                r_valid_out <= 1'b0;
                r_sop_out   <= 1'b0;
                r_eop_out   <= 1'b0;
            end else begin
                r_valid_out <= r_valid_out;
                r_sop_out   <= r_sop_out;
                r_eop_out   <= r_eop_out;
            end
        end
    end

    mode_debouncer #(
        .STABLE_FRAMES (STABLE_FRAMES)
    ) u_mode_debouncer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_sop_strobe (w_sop_strobe),
        .i_freq_flag  (bus.freq_flag),
        .o_mode       (w_mode)
    );

    assign bus.ready_out   = w_ready_out;
    assign bus.valid_out   = r_valid_out;
    assign bus.sop_out     = r_sop_out;
    assign bus.eop_out     = r_eop_out;
    assign bus.data_out    = r_data_out;
    assign bus.col_out     = r_col_out;
    assign bus.row_out     = r_row_out;
    assign bus.mode_out    = w_mode;
    assign bus.len_error   = r_len_error;
    assign bus.frame_count = r_frame_count;

endmodule

// File: tb/tb_filter_frame_sequencer.sv
// Directed bench for filter_frame_sequencer on a reduced 20x6 frame so every
// framing scenario fits in a short run. Expected values come from the beat
// index: row = i / W, col = i % W, data = pix(i).
module tb_filter_frame_sequencer;

    localparam int W = 20;
    localparam int H = 6;
    localparam int N = W * H;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    int   bp_idx;
    int   bp_k;
    int   bp_cyc;
    logic bp_consumed;
    logic bp_accepted;

    logic [1:0] flag_seq [5];
    logic [1:0] mode_seq [5];

    always #5 clk = ~clk;

    filter_frame_sequencer_if #(.DATA_W(12)) u_if ();

    filter_frame_sequencer #(
        .IMG_W         (W),
        .IMG_H         (H),
        .DATA_W        (12),
        .STABLE_FRAMES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    function automatic logic [11:0] pix(input int i);
        return 12'((i * 37 + 5) % 4096);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one upstream beat, clock it, and return #1 after the edge.
    task automatic drive(input logic v, input logic s, input logic e,
                         input logic [11:0] d, input logic [1:0] f);
        u_if.valid_in  = v;
        u_if.sop_in    = s;
        u_if.eop_in    = e;
        u_if.data_in   = d;
        u_if.freq_flag = f;
        @(posedge clk);
        #1;
    endtask

    // Stream beats first..last of a frame with ready_in=1 and check each one.
    task automatic run_beats(input int first, input int last, input int eop_at,
                             input logic [1:0] flag, input logic [1:0] mode,
                             input logic err_first);
        for (int i = first; i <= last; i++) begin
            logic exp_err;
            drive(1'b1, i == 0, i == eop_at, pix(i), flag);
            exp_err = (i == first && err_first) || (i == eop_at && i != N - 1) ||
                      (i == N - 1 && eop_at != N - 1);
            chk("beat_valid", 32'(u_if.valid_out), 32'd1);
            chk("beat_row",   32'(u_if.row_out),   32'(i / W));
            chk("beat_col",   32'(u_if.col_out),   32'(i % W));
            chk("beat_data",  32'(u_if.data_out),  32'(pix(i)));
            chk("beat_sop",   32'(u_if.sop_out),   32'(i == 0));
            chk("beat_eop",   32'(u_if.eop_out),   32'((i == eop_at) || (i == N - 1)));
            chk("beat_lerr",  32'(u_if.len_error), 32'(exp_err));
            chk("beat_mode",  32'(u_if.mode_out),  32'(mode));
        end
    endtask

    initial begin
        flag_seq[0] = 2'd1; flag_seq[1] = 2'd1; flag_seq[2] = 2'd3; flag_seq[3] = 2'd1; flag_seq[4] = 2'd1;
        mode_seq[0] = 2'd0; mode_seq[1] = 2'd1; mode_seq[2] = 2'd1; mode_seq[3] = 2'd1; mode_seq[4] = 2'd1;

        u_if.valid_in  = 1'b0;
        u_if.sop_in    = 1'b0;
        u_if.eop_in    = 1'b0;
        u_if.data_in   = 12'd0;
        u_if.freq_flag = 2'd0;
        u_if.ready_in  = 1'b0;

        // Reset state
        #2;
        chk("rst_valid", 32'(u_if.valid_out),   32'd0);
        chk("rst_sop",   32'(u_if.sop_out),     32'd0);
        chk("rst_eop",   32'(u_if.eop_out),     32'd0);
        chk("rst_data",  32'(u_if.data_out),    32'd0);
        chk("rst_col",   32'(u_if.col_out),     32'd0);
        chk("rst_row",   32'(u_if.row_out),     32'd0);
        chk("rst_mode",  32'(u_if.mode_out),    32'd0);
        chk("rst_lerr",  32'(u_if.len_error),   32'd0);
        chk("rst_fc",    32'(u_if.frame_count), 32'd0);
        chk("rst_ready", 32'(u_if.ready_out),   32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        u_if.ready_in = 1'b1;

        // Non-SOP beat while idle is dropped
        drive(1'b1, 1'b0, 1'b0, 12'h123, 2'd2);
        chk("idle_drop_valid", 32'(u_if.valid_out), 32'd0);

        // Two clean frames with flag 2: mode moves to 2 at the second SOP
        run_beats(0, N - 1, N - 1, 2'd2, 2'd0, 1'b0);
        chk("fc_after_f1", 32'(u_if.frame_count), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 12'd0, 2'd2);
        chk("gap_valid", 32'(u_if.valid_out), 32'd0);
        run_beats(0, N - 1, N - 1, 2'd2, 2'd2, 1'b0);
        chk("fc_after_f2", 32'(u_if.frame_count), 32'd2);
        drive(1'b0, 1'b0, 1'b0, 12'd0, 2'd2);

        // Random backpressure: output must track beat bp_k until it is taken
        bp_idx = 0;
        bp_k   = 0;
        bp_cyc = 0;
        while (bp_k < N && bp_cyc < 8 * N) begin
            u_if.ready_in  = 1'($urandom_range(0, 1));
            u_if.valid_in  = (bp_idx < N);
            u_if.sop_in    = (bp_idx == 0);
            u_if.eop_in    = (bp_idx == N - 1);
            u_if.data_in   = pix(bp_idx);
            u_if.freq_flag = 2'd2;
            #1;
            if (u_if.valid_out) begin
                chk("bp_data", 32'(u_if.data_out), 32'(pix(bp_k)));
                chk("bp_row",  32'(u_if.row_out),  32'(bp_k / W));
                chk("bp_col",  32'(u_if.col_out),  32'(bp_k % W));
                chk("bp_eop",  32'(u_if.eop_out),  32'(bp_k == N - 1));
            end
            bp_consumed = u_if.valid_out & u_if.ready_in;
            bp_accepted = u_if.valid_in & u_if.ready_out;
            @(posedge clk);
            #1;
            if (bp_consumed) bp_k++;
            if (bp_accepted) bp_idx++;
            bp_cyc++;
        end
        chk("bp_beats_out", 32'(bp_k), 32'(N));
        u_if.ready_in = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 12'd0, 2'd2);
        chk("bp_fc", 32'(u_if.frame_count), 32'd3);

        // Early EOP at beat 50 (row 2, col 10)
        run_beats(0, 50, 50, 2'd2, 2'd2, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 12'd0, 2'd2);
        chk("early_lerr_once", 32'(u_if.len_error),   32'd0);
        chk("early_fc",        32'(u_if.frame_count), 32'd3);
        drive(1'b1, 1'b0, 1'b0, pix(7), 2'd2);
        chk("early_drop", 32'(u_if.valid_out), 32'd0);
        run_beats(0, N - 1, N - 1, 2'd2, 2'd2, 1'b0);
        chk("early_next_fc", 32'(u_if.frame_count), 32'd4);

        // Missing EOP: forced at last beat, then 5 extra beats dropped
        run_beats(0, N - 1, -1, 2'd2, 2'd2, 1'b0);
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 1'b0, 1'b0, pix(j + 3), 2'd2);
            chk("extra_drop_valid", 32'(u_if.valid_out), 32'd0);
            chk("extra_drop_lerr",  32'(u_if.len_error), 32'd0);
        end
        run_beats(0, N - 1, N - 1, 2'd2, 2'd2, 1'b0);

        // SOP mid-frame restarts at (0,0) with a length error
        run_beats(0, 29, -1, 2'd2, 2'd2, 1'b0);
        run_beats(0, N - 1, N - 1, 2'd2, 2'd2, 1'b1);

        // SOP and EOP on the same beat
        drive(1'b1, 1'b1, 1'b1, pix(0), 2'd2);
        chk("se_valid", 32'(u_if.valid_out), 32'd1);
        chk("se_sop",   32'(u_if.sop_out),   32'd1);
        chk("se_eop",   32'(u_if.eop_out),   32'd1);
        chk("se_lerr",  32'(u_if.len_error), 32'd1);
        chk("se_col",   32'(u_if.col_out),   32'd0);
        drive(1'b1, 1'b0, 1'b0, pix(1), 2'd2);
        chk("se_then_drop", 32'(u_if.valid_out), 32'd0);

        // Asynchronous reset in the middle of row 3
        run_beats(0, 69, -1, 2'd2, 2'd2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(u_if.valid_out),   32'd0);
        chk("arst_sop",   32'(u_if.sop_out),     32'd0);
        chk("arst_data",  32'(u_if.data_out),    32'd0);
        chk("arst_col",   32'(u_if.col_out),     32'd0);
        chk("arst_row",   32'(u_if.row_out),     32'd0);
        chk("arst_mode",  32'(u_if.mode_out),    32'd0);
        chk("arst_fc",    32'(u_if.frame_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 1'b0, 1'b0, pix(70 + j), 2'd2);
            chk("arst_drop", 32'(u_if.valid_out), 32'd0);
        end

        // Flag sequence 1,1,3,1,1 on consecutive SOPs; flag ignored mid-frame
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 1'b0, pix(0), flag_seq[k]);
            chk("seq_sop",  32'(u_if.sop_out),   32'd1);
            chk("seq_mode", 32'(u_if.mode_out),  32'(mode_seq[k]));
            chk("seq_lerr", 32'(u_if.len_error), 32'(k > 0));
            for (int j = 1; j < 4; j++) begin
                drive(1'b1, 1'b0, 1'b0, pix(j), 2'd0);
                chk("seq_mode_mid", 32'(u_if.mode_out), 32'(mode_seq[k]));
            end
        end

        drive(1'b0, 1'b0, 1'b0, 12'd0, 2'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
